// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO bus controller: FSM state encoding,
// default peripheral region and a small elaboration-time helper.
package mio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAM_ACC = 2'd1,
    ST_IO_ACC  = 2'd2,
    ST_DONE    = 2'd3
  } mio_state_e;

  localparam logic [3:0] IO_REGION_DFLT = 4'hE;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU requests to a synchronous word RAM or a
// peripheral bus and returns a one-cycle MIO_ready completion pulse.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int         ADDR_W     = 10,
  parameter int         RAM_WAIT   = 1,
  parameter int         IO_TIMEOUT = 15,
  parameter logic [3:0] IO_REGION  = IO_REGION_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              mio_ready,
  output logic              bus_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       io_addr,
  output logic              io_rd,
  output logic              io_we,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack,
  output logic [1:0]        mio_state
);

  // One counter serves both the RAM wait and the peripheral timeout.
  localparam int CNT_W = max_int(1, $clog2(max_int(RAM_WAIT, IO_TIMEOUT) + 1));
  localparam logic [CNT_W-1:0] RAM_LAST = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] IO_LAST  = CNT_W'(IO_TIMEOUT);

  mio_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             ready_q;
  logic             err_q;
  logic             ram_we_q;
  logic             io_rd_q;
  logic             io_we_q;

  logic             is_io;

  assign is_io = (cpu_addr[31:28] == IO_REGION);

  // Strobes and the completion pulse are registered so they are glitch-free
  // and fall immediately with the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      ram_we_q <= 1'b0;
      io_rd_q  <= 1'b0;
      io_we_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_req) begin
            addr_q   <= cpu_addr;
            wdata_q  <= cpu_wdata;
            cnt_q    <= '0;
            ram_we_q <= cpu_we & ~is_io;
            io_rd_q  <= ~cpu_we & is_io;
            io_we_q  <= cpu_we & is_io;
            state_q  <= is_io ? ST_IO_ACC : ST_RAM_ACC;
          end
        end
        ST_RAM_ACC: begin
          ram_we_q <= 1'b0;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == RAM_LAST) begin
            rdata_q <= ram_rdata;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_IO_ACC: begin
          // A late ack on the final timeout cycle still counts as success.
          if (io_ack) begin
            rdata_q <= io_rdata;
            ready_q <= 1'b1;
            io_rd_q <= 1'b0;
            io_we_q <= 1'b0;
            state_q <= ST_DONE;
          end else if (cnt_q == IO_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            ready_q <= 1'b1;
            io_rd_q <= 1'b0;
            io_we_q <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign mio_ready = ready_q;
  assign bus_err   = err_q;
  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign ram_we    = ram_we_q;
  assign ram_wdata = wdata_q;
  assign io_addr   = addr_q;
  assign io_rd     = io_rd_q;
  assign io_we     = io_we_q;
  assign io_wdata  = wdata_q;
  assign mio_state = state_q;

endmodule
